decode_imm_stage: RTL
=====================

Name: decode_imm_stage

Overview:
- Registered instruction-decode stage that produces the operand-select inputs consumed by the ALU operand-B mux: opcode, imm_en, and all eight sign-extended immediates. Also produces rd, rs1, rs2, funct3, funct7 and pc.
- Sits between instruction fetch and the execute path.
- Uses a valid/ready handshake with a DEPTH-entry skid FIFO, so fetch and execute can stall independently without losing throughput.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- NOP_INST, 32'h00000013, substitution word (addi x0,x0,0) used for illegal instructions when DECODE_ILLEGAL_EN is defined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discards all buffered entries and any input presented in the same cycle.
- in_valid  in  1  fetch presents inst and pc.
- in_ready  out  1  stage can accept.
- inst  in  32  raw instruction word.
- pc  in  32  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_pc  out  32  pc of head entry.
- opcode  out  7  inst[6:0].
- rd, rs1, rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- imm_en  out  1  operand B is an immediate.
- imm_I, imm_L, imm_JR  out  32 each  {{20{i[31]}},i[31:20]}.
- imm_S  out  32  {{20{i[31]}},i[31:25],i[11:7]}.
- imm_B  out  32  {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}.
- imm_LUI, imm_AU  out  32 each  {i[31:12],12'b0}.
- imm_J  out  32  {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
- illegal  out  1  head entry had an unrecognised opcode.

Behaviour:
- Reset:
  - While rst=1: in_ready=0.
  - First cycle after rst deasserts: in_ready=1, out_valid=0, FIFO count=0, all data outputs 32'h0 / 0.
- Decode is performed on the input side and the decoded fields are stored per entry. Outputs come directly from registers at the head entry, with no combinational path from inst to any output.
- Latency: an entry accepted in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty.
- Accept condition: in_valid & in_ready & !flush.
- Pop condition: out_valid & out_ready & !flush.
- in_ready = !rst & (count < DEPTH); it does not depend on out_ready.
- Full FIFO with simultaneous pop: no push occurs that cycle. This conservative ready is deliberate.
- Simultaneous push and pop when count is between 1 and DEPTH-1: count is unchanged and order is preserved.
- Empty FIFO: out_valid=0, and the data outputs hold their last value. Consumers must ignore data while out_valid=0.
- imm_en=1 for opcodes 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111.
- imm_en=0 for 0110011 (R-type) and for all other opcodes.
- flush: next cycle out_valid=0, count=0, and read/write pointers are reset to 0. Input presented in the flush cycle is dropped even if in_ready=1.
- rst asserted mid-operation overrides flush and all handshakes. Buffered entries are lost.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined:
  - Legal opcodes are the nine listed above plus 0001111 (FENCE) and 1110011 (SYSTEM).
  - Any other opcode is stored with all fields decoded from NOP_INST (imm_en=1, imm_I=0, opcode 0010011, rd=0, rs1=0) and illegal=1 for that entry.
  - out_pc keeps the original pc.
- Not defined:
  - illegal is tied to 0.
  - All words are decoded raw, and imm_en=0 for unrecognised opcodes.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) accepted cycle N, out_ready=1 -> cycle N+1: out_valid=1, opcode=0010011, imm_en=1, imm_I=0xFFFFFFFF, rd=1, rs1=2, funct3=0.
- sw x5,8(x2) (0x00512423), then beq x0,x0,-4 (0xFE000EE3) -> imm_S=0x00000008 for the first; imm_B=0xFFFFFFFC, imm_en=1 for the second; order preserved.
- out_ready=0 with in_valid=1 continuously for 3 words -> 2 accepted, in_ready=0 from the cycle count reaches 2. out_ready=1 -> words emerge in order and in_ready returns to 1 the cycle after the first pop.
- FIFO full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, count=0. Dropped input never appears.
- add x3,x1,x2 (0x002081B3) -> imm_en=0, rs2=2, funct7=0.
- Inst 0xFFFFFFFF: with DECODE_ILLEGAL_EN -> illegal=1, opcode=0010011, imm_I=0, rd=0. Without the macro -> illegal=0, opcode=1111111, imm_en=0.
- rst=1 mid-stream with 2 entries buffered -> out_valid=0, in_ready=0. After release: in_ready=1, outputs zero.

Source files
------------

// File: rtl/decode_imm_stage.sv
// Registered RV32 decode stage: decodes on the input side into a DEPTH-entry skid FIFO.
// Optional macro DECODE_ILLEGAL_EN replaces unrecognised opcodes with NOP_INST and flags them.
module decode_imm_stage #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        imm_en,
   output logic [31:0] imm_I,
   output logic [31:0] imm_L,
   output logic [31:0] imm_JR,
   output logic [31:0] imm_S,
   output logic [31:0] imm_B,
   output logic [31:0] imm_LUI,
   output logic [31:0] imm_AU,
   output logic [31:0] imm_J,
   output logic        illegal
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        imm_en;
      logic        illegal;
      logic [31:0] imm_i;
      logic [31:0] imm_s;
      logic [31:0] imm_b;
      logic [31:0] imm_u;
      logic [31:0] imm_j;
   } entry_t;

   entry_t          r_mem [DEPTH];
   entry_t          r_head;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   w_rd_ptr_nxt;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   entry_t          w_dec;
   entry_t          w_head_nxt;
   logic [31:0]     w_word;
   logic            w_bad;
   logic            w_imm_en;
   logic            w_push;
   logic            w_pop;

   // Opcodes whose operand B comes from an immediate.
   always_comb begin
      w_imm_en = 1'b0;
      case (w_word[6:0])
         7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
         7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111: w_imm_en = 1'b1;
         default:                                        w_imm_en = 1'b0;
      endcase
   end

`ifdef DECODE_ILLEGAL_EN
   logic w_known;

   always_comb begin
      w_known = 1'b0;
      case (inst[6:0])
         7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011,
         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011,
         7'b0001111, 7'b1110011: w_known = 1'b1;
         default:                w_known = 1'b0;
      endcase
   end

   assign w_word = w_known ? inst : NOP_INST;
   assign w_bad  = !w_known;
`else
   assign w_word = inst;
   assign w_bad  = 1'b0;
`endif

   always_comb begin
      w_dec         = '0;
      w_dec.pc      = pc;
      w_dec.opcode  = w_word[6:0];
      w_dec.rd      = w_word[11:7];
      w_dec.rs1     = w_word[19:15];
      w_dec.rs2     = w_word[24:20];
      w_dec.funct3  = w_word[14:12];
      w_dec.funct7  = w_word[31:25];
      w_dec.imm_en  = w_imm_en;
      w_dec.illegal = w_bad;
      w_dec.imm_i   = {{20{w_word[31]}}, w_word[31:20]};
      w_dec.imm_s   = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
      w_dec.imm_b   = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0};
      w_dec.imm_u   = {w_word[31:12], 12'b0};
      w_dec.imm_j   = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20], w_word[30:21], 1'b0};
   end

   // Ready deliberately ignores out_ready: a full FIFO never pushes, even while popping.
   assign in_ready  = !rst && (r_count < FULL);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // The slot being written becomes the head only when the FIFO drains to it this cycle.
   assign w_head_nxt = (w_push && (w_rd_ptr_nxt == r_wr_ptr)) ? w_dec : r_mem[w_rd_ptr_nxt];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_dec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         // Data holds its last value while the FIFO is empty.
         if (w_count_nxt != '0) r_head <= w_head_nxt;
      end
   end

   assign out_pc  = r_head.pc;
   assign opcode  = r_head.opcode;
   assign rd      = r_head.rd;
   assign rs1     = r_head.rs1;
   assign rs2     = r_head.rs2;
   assign funct3  = r_head.funct3;
   assign funct7  = r_head.funct7;
   assign imm_en  = r_head.imm_en;
   assign imm_I   = r_head.imm_i;
   assign imm_L   = r_head.imm_i;
   assign imm_JR  = r_head.imm_i;
   assign imm_S   = r_head.imm_s;
   assign imm_B   = r_head.imm_b;
   assign imm_LUI = r_head.imm_u;
   assign imm_AU  = r_head.imm_u;
   assign imm_J   = r_head.imm_j;
   assign illegal = r_head.illegal;

endmodule
